// File: rtl/ll_pkg.sv
// Shared types and helpers for the line-length window accumulator.
// Clamp helper supports sample widths up to LL_MAX_DW bits.
package ll_pkg;

  typedef enum logic {FILL, RUN} ll_state_t;

  localparam int LL_DATA_WIDTH = 32;
  localparam int LL_MAX_DW     = 64;

  // A negative abs-diff can only be the upstream abs overflow; saturate it to max positive.
  function automatic logic [LL_MAX_DW-1:0] ll_clamp(input logic [LL_MAX_DW-1:0] x,
                                                     input int dw);
    logic [LL_MAX_DW-1:0] max_pos;
    max_pos = (LL_MAX_DW'(1) << (dw - 1)) - LL_MAX_DW'(1);
    if (((x >> (dw - 1)) & LL_MAX_DW'(1)) != '0) return max_pos;
    return x;
  endfunction

endpackage

// File: rtl/ll_win_buf.sv
// Circular sample store for the sliding window: combinational read at the
// write address, synchronous write, storage deliberately not reset.
module ll_win_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/ll_window_acc.sv
// Sliding-window line-length accumulator. Optional threshold compare is
// built when the LL_THRESH_EN macro is defined.
module ll_window_acc
  import ll_pkg::*;
#(
  parameter int DATA_WIDTH = LL_DATA_WIDTH,
  parameter int WIN_LEN    = 256,
  parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(WIN_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  output logic                  window_full,
`ifdef LL_THRESH_EN
  input  logic [ACC_WIDTH-1:0]  thresh,
  output logic                  over_thresh,
`endif
  output logic                  dbg_state
);

  localparam int AW = $clog2(WIN_LEN);

  // Handshake: a sample is taken on every edge with din_valid=1 and clr=0; there is
  // no ready (full rate, no backpressure). dout_valid is a one-cycle pulse, no ack.
  ll_state_t             state;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         fill_cnt;
  logic [ACC_WIDTH-1:0]  sum;
  logic [ACC_WIDTH-1:0]  sum_next;
  logic [ACC_WIDTH-1:0]  old_ext;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  accept;

  assign accept    = din_valid & ~clr;
  assign sample    = DATA_WIDTH'(ll_clamp(LL_MAX_DW'(din), DATA_WIDTH));
  assign old_ext   = (state == FILL) ? '0 : ACC_WIDTH'(rd_data);
  assign sum_next  = sum + ACC_WIDTH'(sample) - old_ext;
  assign dbg_state = state;

  ll_win_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (WIN_LEN),
    .ADDR_WIDTH (AW)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .addr  (wr_ptr),
    .wdata (sample),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      sum         <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      window_full <= 1'b0;
`ifdef LL_THRESH_EN
      over_thresh <= 1'b0;
`endif
    end else if (clr) begin
      state       <= FILL;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      sum         <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      window_full <= 1'b0;
`ifdef LL_THRESH_EN
      over_thresh <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
      if (accept) begin
        sum    <= sum_next;
        wr_ptr <= wr_ptr + AW'(1);
        // Publish on every RUN accept and on the accept that completes the window.
        if (state == RUN || fill_cnt == AW'(WIN_LEN - 1)) begin
          dout       <= sum_next;
          dout_valid <= 1'b1;
`ifdef LL_THRESH_EN
          over_thresh <= (sum_next > thresh);
`endif
        end
        case (state)
          FILL: begin
            fill_cnt <= fill_cnt + AW'(1);
            if (fill_cnt == AW'(WIN_LEN - 1)) begin
              state       <= RUN;
              window_full <= 1'b1;
            end
          end
          RUN:     state <= RUN;
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ll_window_acc.sv
// Randomized scoreboard bench for ll_window_acc at WIN_LEN=4, DATA_WIDTH=32;
// the threshold path is exercised when LL_THRESH_EN is defined.
module tb_ll_window_acc;

  localparam int DW  = 32;
  localparam int WIN = 4;
  localparam int ACC = DW + $clog2(WIN);
  localparam int EW  = ACC + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clr = 1'b0;
  logic [DW-1:0]  din = '0;
  logic           din_valid = 1'b0;
  logic [ACC-1:0] dout;
  logic           dout_valid;
  logic           window_full;
  logic [ACC-1:0] thresh = ACC'(10);
  logic           dbg_state;
`ifdef LL_THRESH_EN
  logic           over_thresh;
`endif

  ll_window_acc #(.DATA_WIDTH(DW), .WIN_LEN(WIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .din         (din),
    .din_valid   (din_valid),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .window_full (window_full),
`ifdef LL_THRESH_EN
    .thresh      (thresh),
    .over_thresh (over_thresh),
`endif
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: the last WIN accepted (clamped) samples, summed directly.
  logic [EW-1:0] exp_q[$];
  longint        win_q[$];

  function automatic longint model_clamp(input logic [DW-1:0] d);
    return (d >= 32'h8000_0000) ? longint'(32'h7FFF_FFFF) : longint'(d);
  endfunction

  task automatic drive(input logic v, input logic c, input logic [DW-1:0] d);
    longint s;
    logic   ov;
    din_valid = v;
    clr       = c;
    din       = d;
    if (c) begin
      win_q.delete();
    end else if (v) begin
      win_q.push_back(model_clamp(d));
      if (win_q.size() > WIN) void'(win_q.pop_front());
      if (win_q.size() == WIN) begin
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        ov = (s > longint'(thresh));
        exp_q.push_back({ov, 1'b1, ACC'(s)});
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    win_q.delete();
    exp_q.delete();
    #1;
    check("rst_async_dout", 64'(dout), 64'd0);
    check("rst_async_valid", 64'(dout_valid), 64'd0);
    check("rst_async_full", 64'(window_full), 64'd0);
`ifdef LL_THRESH_EN
    check("rst_async_over", 64'(over_thresh), 64'd0);
`endif
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every pulse; otherwise outputs must hold the last expected values.
  logic           last_clr = 1'b0;
  logic [ACC-1:0] hold_dout = '0;
  logic           hold_wf = 1'b0;
  logic           hold_over = 1'b0;

  always @(posedge clk) last_clr <= clr & ~rst;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      hold_dout = '0;
      hold_wf   = 1'b0;
      hold_over = 1'b0;
    end else if (dout_valid) begin
      if (last_clr) check("pulse_after_clr", 64'd1, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_dout", 64'(dout), 64'(e[ACC-1:0]));
        check("pulse_full", 64'(window_full), 64'(e[ACC]));
        check("pulse_state", 64'(dbg_state), 64'(e[ACC]));
`ifdef LL_THRESH_EN
        check("pulse_over", 64'(over_thresh), 64'(e[ACC+1]));
`endif
        hold_dout = e[ACC-1:0];
        hold_wf   = e[ACC];
        hold_over = e[ACC+1];
      end
    end else begin
      if (last_clr) begin
        hold_dout = '0;
        hold_wf   = 1'b0;
        hold_over = 1'b0;
      end
      check("hold_dout", 64'(dout), 64'(hold_dout));
      check("hold_full", 64'(window_full), 64'(hold_wf));
      check("hold_state", 64'(dbg_state), 64'(hold_wf));
`ifdef LL_THRESH_EN
      check("hold_over", 64'(over_thresh), 64'(hold_over));
`endif
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_valid", 64'(dout_valid), 64'd0);
    check("reset_full", 64'(window_full), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill then steady state.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, DW'(i));
      check("fill_no_pulse", 64'(dout_valid), 64'd0);
    end
    drive(1'b1, 1'b0, 32'd4);
    check("fill_done_dout", 64'(dout), 64'd10);
    check("fill_done_full", 64'(window_full), 64'd1);
    drive(1'b1, 1'b0, 32'd5);
    check("run_dout_14", 64'(dout), 64'd14);
    drive(1'b1, 1'b0, 32'd6);
    check("run_dout_18", 64'(dout), 64'd18);

    // Sparse valids.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'd7);
      drive(1'b0, 1'b0, $urandom());
      drive(1'b0, 1'b0, $urandom());
    end
    check("gap_dout_28", 64'(dout), 64'd28);

    // Saturation of the abs overflow value.
    drive(1'b1, 1'b0, 32'h8000_0000);
    check("clamp_one", 64'(dout), 64'd2147483668);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h8000_0000);
    check("clamp_full_window", 64'(dout), 64'd8589934588);

    // clr wins over a simultaneous sample.
    drive(1'b1, 1'b1, 32'd9);
    check("clr_dout", 64'(dout), 64'd0);
    check("clr_full", 64'(window_full), 64'd0);
    check("clr_valid", 64'(dout_valid), 64'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'd1);
    check("after_clr_dout", 64'(dout), 64'd4);

    // Async reset mid-FILL, then mid-RUN right after a pulse.
    drive(1'b1, 1'b1, 32'd0);
    drive(1'b1, 1'b0, 32'd3);
    drive(1'b1, 1'b0, 32'd3);
    async_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'd20);
    check("pre_rst_pulse", 64'(dout_valid), 64'd1);
    async_reset();

    // Threshold window at thresh=10.
    thresh = ACC'(10);
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, DW'(i));
`ifdef LL_THRESH_EN
    check("thresh_eq_not_over", 64'(over_thresh), 64'd0);
`endif
    drive(1'b1, 1'b0, 32'd5);
`ifdef LL_THRESH_EN
    check("thresh_over", 64'(over_thresh), 64'd1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic          v;
      logic          c;
      logic [DW-1:0] d;
      int            r;
      if (n % 100 == 0) thresh = ACC'($urandom_range(0, 3000));
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r == 0) d = 32'h8000_0000;
      else if (r == 1) d = 32'h7FFF_FFFF;
      else if (r == 2) d = $urandom();
      else d = DW'($urandom_range(0, 1000));
      drive(v, c, d);
    end

    repeat (3) drive(1'b0, 1'b0, 32'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
